dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Shares the single data-memory port between the MEM-stage load path and a small buffer of committed stores. Loads get the port by default; committed stores are queued and drained in idle cycles, when the buffer is full, or when a store has aged too long. Loads that hit a word with a pending store wait until that store drains. The block sits between the MEM stage / commit logic and the data-memory interface (`data_*_2DM` / `data_read_fDM`).

## Interface
- `SB_DEPTH`, default 4: store-buffer entries; power of two, at least 2.
- `AGE_MAX`, default 8: cycles the head store may wait before it is forced to drain.
- `CLK`  in  1  clock.
- `RESET`  in  1  asynchronous, active-low reset.
- `st_valid`  in  1  committed store offered.
- `st_ready`  out  1  store accepted this cycle.
- `st_addr`  in  32  store byte address (may be unaligned for partial stores).
- `st_data`  in  32  store data, already lane-shifted.
- `st_size`  in  2  0=word, 1=byte, 2=half, 3=three bytes.
- `ld_valid`  in  1  load request.
- `ld_ready`  out  1  load granted the port this cycle.
- `ld_addr`  in  32  load address.
- `ld_tag`  in  6  physical destination map.
- `flush`  in  1  squash all speculative loads.
- `ld_done`  out  1  load data valid.
- `ld_done_tag`  out  6  tag of the completed load.
- `ld_data`  out  32  raw word read from memory.
- `data_address_2DM`  out  32  memory address.
- `data_write_2DM`  out  32  memory write data.
- `data_write_size_2DM`  out  2  write size; same encoding as `st_size`.
- `MemRead_2DM`  out  1  read strobe.
- `MemWrite_2DM`  out  1  write strobe.
- `data_read_fDM`  in  32  read data, valid in the same cycle as `MemRead_2DM`.
- `sb_count`  out  $clog2(SB_DEPTH)+1  current buffer occupancy.

## Operation
- **Store buffer.** Circular FIFO with head/tail pointers and a count. A store is enqueued when `st_valid && st_ready`. `st_ready = (count != SB_DEPTH)`.
- **Conflict.** A load conflicts when any valid entry has `addr[31:2] == ld_addr[31:2]`.
- **Grant priority.** Evaluated each cycle, exactly one grant at most, first match wins:
  1. Drain the head store if the buffer is full, or `age >= AGE_MAX`.
  2. Grant the load if `ld_valid && !flush && !conflict`.
  3. Drain the head store if the buffer is not empty.
  4. Otherwise idle.
- **Load grant.**
  - `ld_ready=1`; `MemRead_2DM=1`.
  - `data_address_2DM = {ld_addr[31:2], 2'b00}`.
- **Store drain.**
  - `MemWrite_2DM=1`; address, data and size come from the head entry unmodified.
  - The entry is dequeued at the clock edge.
- **Idle.** All memory-port outputs are 0.
- **Age counter.**
  - Reset to 0 on any dequeue, or while the buffer is empty.
  - Otherwise increments by 1 and saturates at `AGE_MAX`.
- **Simultaneous enqueue and dequeue.** Both take effect; count is unchanged. A store enqueued this cycle does not take part in this cycle's conflict check.
- **Response register.**
  - On a load grant: `ld_done<=1`, `ld_done_tag<=ld_tag`, `ld_data<=data_read_fDM`.
  - Otherwise `ld_done<=0`.
- **Flush.**
  - No load grant in a flush cycle.
  - An `ld_done` due in the next cycle is still suppressed if `flush` is high in the grant cycle.
  - Buffered stores are never flushed.

## Timing
- Load latency: grant in cycle N, `ld_done` in cycle N+1.
- Store drain: at the earliest, one cycle after the store was enqueued.
- Port usage: one memory access per cycle at most; `MemRead_2DM` and `MemWrite_2DM` are never both high.
- Reset (async, `RESET=0`):
  - Buffer empty; pointers, count and age are 0.
  - `ld_done=0`, `ld_done_tag=0`, `ld_data=0`.
  - Memory strobes are 0. Memory-port outputs are combinational, so they are 0 during reset.
  - A store or load in flight when reset asserts is lost.
- Pointers wrap modulo `SB_DEPTH`.

## Structure
- **Shared package `mem_pkg`:**
  - Size encodings `SZ_WORD=0`, `SZ_BYTE=1`, `SZ_HALF=2`, `SZ_TRIPLE=3`.
  - Store-entry struct {addr[31:0], data[31:0], size[1:0]}.
- **Sub-module `dmem_store_fifo`:**
  - Contains storage, pointers, count, full/empty, and the parallel word-address compare output `hit`.
  - The arbiter holds the grant logic, the age counter and the response register.

## Test plan
- **Lone load.** Reset, then `ld_valid` with addr 0x1006, tag 5, memory returning 0xDEADBEEF → `MemRead_2DM`=1 at address 0x1004. Next cycle: `ld_done`=1, tag 5, `ld_data`=0xDEADBEEF.
- **Store, then load to the same word.** Store to 0x2000 (data 0x11223344, size 0), then load from 0x2002 → `ld_ready`=0 while the store drains (`MemWrite_2DM`=1 at 0x2000, size 0). The load is granted the following cycle.
- **Full buffer.** Fill 4 stores while loads are continuously valid to a non-conflicting address → the next cycle drains a store and `ld_ready`=0. `st_ready` is 0 while `sb_count`=4.
- **Aging.** One store buffered, non-conflicting loads valid every cycle → the store drains after exactly 8 cycles of waiting (`AGE_MAX`=8).
- **Flush.** `flush` asserted in the same cycle as a valid load → no `MemRead_2DM` and no `ld_done` next cycle. The buffered store still drains.
- **Reset mid-drain.** Assert `RESET` with 3 stores queued → `sb_count`=0 and all strobes 0 immediately. After release, no writes are issued.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared data-memory definitions: store size encodings and the buffered store entry.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD   = 2'd0,
        SZ_BYTE   = 2'd1,
        SZ_HALF   = 2'd2,
        SZ_TRIPLE = 2'd3
    } size_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        size_e       size;
    } st_entry_t;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_LOAD,
        GNT_STORE
    } grant_e;

endpackage

// File: rtl/dmem_store_fifo.sv
// Circular buffer of committed stores with a parallel word-address match against a load.
module dmem_store_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push_i,
    input  st_entry_t        push_entry_i,
    input  logic             pop_i,
    input  logic [29:0]      cmp_word_i,
    output st_entry_t        head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             hit_o
);

    st_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: entry storage is deliberately not reset; an entry only matters once count_q covers it.
    always_ff @(posedge CLK) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] offset;
        hit_o  = 1'b0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, offset} < count_q) && (mem_q[i].addr[31:2] == cmp_word_i)) begin
                hit_o = 1'b1;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between MEM-stage loads and the committed-store buffer.
module dmem_port_arbiter
    import mem_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    parameter int AGE_MAX  = 8
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [31:0]               st_addr,
    input  logic [31:0]               st_data,
    input  logic [1:0]                st_size,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [31:0]               ld_addr,
    input  logic [5:0]                ld_tag,
    input  logic                      flush,
    output logic                      ld_done,
    output logic [5:0]                ld_done_tag,
    output logic [31:0]               ld_data,
    output logic [31:0]               data_address_2DM,
    output logic [31:0]               data_write_2DM,
    output logic [1:0]                data_write_size_2DM,
    output logic                      MemRead_2DM,
    output logic                      MemWrite_2DM,
    input  logic [31:0]               data_read_fDM,
    output logic [$clog2(SB_DEPTH):0] sb_count
);

    localparam int AGE_W = $clog2(AGE_MAX + 1);

    st_entry_t  head;
    logic       sb_full, sb_empty, sb_hit;
    logic       push, pop;
    grant_e     grant;
    logic [AGE_W-1:0] age_q, age_d;
    logic       ld_done_q;
    logic [5:0] ld_done_tag_q;
    logic [31:0] ld_data_q;
    logic       unused_ld_lsb;

    assign st_ready = !sb_full;
    assign push     = st_valid && st_ready;
    assign pop      = (grant == GNT_STORE);

    dmem_store_fifo #(.DEPTH(SB_DEPTH)) u_fifo (
        .CLK          (CLK),
        .RESET        (RESET),
        .push_i       (push),
        .push_entry_i ('{addr: st_addr, data: st_data, size: size_e'(st_size)}),
        .pop_i        (pop),
        .cmp_word_i   (ld_addr[31:2]),
        .head_o       (head),
        .count_o      (sb_count),
        .full_o       (sb_full),
        .empty_o      (sb_empty),
        .hit_o        (sb_hit)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        grant               = GNT_IDLE;
        ld_ready            = 1'b0;
        MemRead_2DM         = 1'b0;
        MemWrite_2DM        = 1'b0;
        data_address_2DM    = '0;
        data_write_2DM      = '0;
        data_write_size_2DM = '0;
        // The load path is gated by RESET so the port stays quiet while reset is held.
        if (!sb_empty && (sb_full || age_q >= AGE_W'(AGE_MAX))) begin
            grant = GNT_STORE;
        end else if (RESET && ld_valid && !flush && !sb_hit) begin
            grant = GNT_LOAD;
        end else if (!sb_empty) begin
            grant = GNT_STORE;
        end
        case (grant)
            GNT_LOAD: begin
                ld_ready         = 1'b1;
                MemRead_2DM      = 1'b1;
                data_address_2DM = {ld_addr[31:2], 2'b00};
            end
            GNT_STORE: begin
                MemWrite_2DM        = 1'b1;
                data_address_2DM    = head.addr;
                data_write_2DM      = head.data;
                data_write_size_2DM = head.size;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (pop || sb_empty) begin
            age_d = '0;
        end else if (age_q == AGE_W'(AGE_MAX)) begin
            age_d = age_q;
        end else begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            age_q         <= '0;
            ld_done_q     <= 1'b0;
            ld_done_tag_q <= '0;
            ld_data_q     <= '0;
        end else begin
            age_q     <= age_d;
            ld_done_q <= (grant == GNT_LOAD);
            if (grant == GNT_LOAD) begin
                ld_done_tag_q <= ld_tag;
                ld_data_q     <= data_read_fDM;
            end
        end
    end

    assign ld_done       = ld_done_q;
    assign ld_done_tag   = ld_done_tag_q;
    assign ld_data       = ld_data_q;
    assign unused_ld_lsb = ^ld_addr[1:0];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: inputs change 1 ns after the rising edge, outputs are checked mid-cycle.
module tb_dmem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_data;
    logic [1:0]  st_size;
    logic        ld_valid, ld_ready;
    logic [31:0] ld_addr;
    logic [5:0]  ld_tag;
    logic        flush;
    logic        ld_done;
    logic [5:0]  ld_done_tag;
    logic [31:0] ld_data;
    logic [31:0] data_address_2DM, data_write_2DM;
    logic [1:0]  data_write_size_2DM;
    logic        MemRead_2DM, MemWrite_2DM;
    logic [31:0] data_read_fDM;
    logic [2:0]  sb_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    dmem_port_arbiter #(.SB_DEPTH(4), .AGE_MAX(8)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .st_valid            (st_valid),
        .st_ready            (st_ready),
        .st_addr             (st_addr),
        .st_data             (st_data),
        .st_size             (st_size),
        .ld_valid            (ld_valid),
        .ld_ready            (ld_ready),
        .ld_addr             (ld_addr),
        .ld_tag              (ld_tag),
        .flush               (flush),
        .ld_done             (ld_done),
        .ld_done_tag         (ld_done_tag),
        .ld_data             (ld_data),
        .data_address_2DM    (data_address_2DM),
        .data_write_2DM      (data_write_2DM),
        .data_write_size_2DM (data_write_size_2DM),
        .MemRead_2DM         (MemRead_2DM),
        .MemWrite_2DM        (MemWrite_2DM),
        .data_read_fDM       (data_read_fDM),
        .sb_count            (sb_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain_all();
        int budget = 20;
        while (sb_count != 0 && budget > 0) begin
            cyc();
            budget--;
        end
        check("drain_empty", 32'(sb_count), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; st_valid = 0; st_addr = 0; st_data = 0; st_size = 0;
        ld_valid = 0; ld_addr = 0; ld_tag = 0; flush = 0; data_read_fDM = 0;
        #3;
        check("rst_count", 32'(sb_count), 32'd0);
        check("rst_ld_done", 32'(ld_done), 32'd0);
        check("rst_ld_tag", 32'(ld_done_tag), 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        check("rst_memrd", 32'(MemRead_2DM), 32'd0);
        check("rst_memwr", 32'(MemWrite_2DM), 32'd0);
        cyc();
        RESET = 1'b1;

        // Lone load
        cyc(); ld_valid = 1; ld_addr = 32'h1006; ld_tag = 6'd5; data_read_fDM = 32'hDEADBEEF; #4;
        check("lone_memrd", 32'(MemRead_2DM), 32'd1);
        check("lone_addr", data_address_2DM, 32'h1004);
        check("lone_ready", 32'(ld_ready), 32'd1);
        check("lone_memwr", 32'(MemWrite_2DM), 32'd0);
        cyc(); ld_valid = 0; #4;
        check("lone_done", 32'(ld_done), 32'd1);
        check("lone_tag", 32'(ld_done_tag), 32'd5);
        check("lone_data", ld_data, 32'hDEADBEEF);

        // A store entering this cycle does not block a same-word load
        cyc(); st_valid = 1; st_addr = 32'h5000; st_data = 32'hA5A5A5A5; st_size = 2'd0;
        ld_valid = 1; ld_addr = 32'h5000; ld_tag = 6'd7; #4;
        check("same_cyc_ready", 32'(ld_ready), 32'd1);
        cyc(); st_valid = 0; ld_valid = 0; #4;
        check("same_cyc_drain", 32'(MemWrite_2DM), 32'd1);
        check("same_cyc_waddr", data_address_2DM, 32'h5000);
        check("same_cyc_wdata", data_write_2DM, 32'hA5A5A5A5);
        check("same_cyc_done_tag", 32'(ld_done_tag), 32'd7);

        // Store then load to the same word
        cyc(); st_valid = 1; st_addr = 32'h2000; st_data = 32'h11223344; st_size = 2'd0; #4;
        check("sl_st_ready", 32'(st_ready), 32'd1);
        check("sl_idle_wr", 32'(MemWrite_2DM), 32'd0);
        cyc(); st_valid = 0; ld_valid = 1; ld_addr = 32'h2002; ld_tag = 6'd9; #4;
        check("sl_ld_blocked", 32'(ld_ready), 32'd0);
        check("sl_memrd", 32'(MemRead_2DM), 32'd0);
        check("sl_memwr", 32'(MemWrite_2DM), 32'd1);
        check("sl_waddr", data_address_2DM, 32'h2000);
        check("sl_wdata", data_write_2DM, 32'h11223344);
        check("sl_wsize", 32'(data_write_size_2DM), 32'd0);
        cyc(); #4;
        check("sl_ld_granted", 32'(ld_ready), 32'd1);
        check("sl_ld_addr", data_address_2DM, 32'h2000);
        cyc(); ld_valid = 0; #4;
        check("sl_done", 32'(ld_done), 32'd1);
        check("sl_done_tag", 32'(ld_done_tag), 32'd9);

        // Full buffer with loads competing every cycle
        for (int i = 0; i < 4; i++) begin
            cyc(); st_valid = 1; st_addr = 32'h3000 + 32'(4 * i); st_data = 32'(i); st_size = 2'd1;
            ld_valid = 1; ld_addr = 32'h8000; ld_tag = 6'd1; #4;
            check("full_fill_ld", 32'(ld_ready), 32'd1);
        end
        cyc(); st_valid = 0; #4;
        check("full_count", 32'(sb_count), 32'd4);
        check("full_st_ready", 32'(st_ready), 32'd0);
        check("full_memwr", 32'(MemWrite_2DM), 32'd1);
        check("full_waddr", data_address_2DM, 32'h3000);
        check("full_wsize", 32'(data_write_size_2DM), 32'd1);
        check("full_ld_ready", 32'(ld_ready), 32'd0);
        cyc(); #4;
        check("full_after_count", 32'(sb_count), 32'd3);
        check("full_after_ld", 32'(ld_ready), 32'd1);
        check("full_after_st_ready", 32'(st_ready), 32'd1);
        cyc(); ld_valid = 0; #4;
        check("full_order", data_address_2DM, 32'h3004);
        drain_all();

        // Aging: one store held back by loads for exactly AGE_MAX cycles
        cyc(); st_valid = 1; st_addr = 32'h4000; st_data = 32'h55; st_size = 2'd2;
        ld_valid = 1; ld_addr = 32'h8000; #4;
        check("age_enq_ld", 32'(ld_ready), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            cyc(); st_valid = 0; #4;
            check("age_wait", 32'(MemWrite_2DM), 32'd0);
        end
        cyc(); #4;
        check("age_memwr", 32'(MemWrite_2DM), 32'd1);
        check("age_waddr", data_address_2DM, 32'h4000);
        check("age_wsize", 32'(data_write_size_2DM), 32'd2);
        check("age_ld_ready", 32'(ld_ready), 32'd0);
        cyc(); ld_valid = 0; #4;
        check("age_count", 32'(sb_count), 32'd0);

        // Flush squashes the load; the buffered store still drains
        cyc(); st_valid = 1; st_addr = 32'h6000; st_data = 32'h66; st_size = 2'd0; #4;
        cyc(); st_valid = 0; ld_valid = 1; ld_addr = 32'h9000; ld_tag = 6'd3; flush = 1; #4;
        check("flush_memrd", 32'(MemRead_2DM), 32'd0);
        check("flush_ld_ready", 32'(ld_ready), 32'd0);
        check("flush_memwr", 32'(MemWrite_2DM), 32'd1);
        check("flush_waddr", data_address_2DM, 32'h6000);
        cyc(); ld_valid = 0; flush = 0; #4;
        check("flush_no_done", 32'(ld_done), 32'd0);
        check("flush_count", 32'(sb_count), 32'd0);

        // Reset while three stores are queued and one is draining
        for (int i = 0; i < 3; i++) begin
            cyc(); st_valid = 1; st_addr = 32'h7000 + 32'(4 * i); st_data = 32'(i);
            ld_valid = 1; ld_addr = 32'h8000; ld_tag = 6'd2;
        end
        cyc(); st_valid = 0; ld_valid = 0; #1;
        check("rmid_count", 32'(sb_count), 32'd3);
        check("rmid_memwr", 32'(MemWrite_2DM), 32'd1);
        RESET = 1'b0; #1;
        check("rmid_rst_count", 32'(sb_count), 32'd0);
        check("rmid_rst_memwr", 32'(MemWrite_2DM), 32'd0);
        check("rmid_rst_memrd", 32'(MemRead_2DM), 32'd0);
        check("rmid_rst_done", 32'(ld_done), 32'd0);
        cyc(); RESET = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(); #4;
            check("rmid_no_write", 32'(MemWrite_2DM), 32'd0);
        end
        check("rmid_final_count", 32'(sb_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
